// File: rtl/ahb3lite_irq_gen_if.sv
// AHB3-lite bus bundle between a master and the interrupt generator slave.
interface ahb3lite_irq_gen_if;
    logic        HSEL;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        HREADYOUT;

    modport master (
        output HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HRESP, HREADYOUT
    );

    modport slave (
        input  HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HRESP, HREADYOUT
    );
endinterface

// File: rtl/ahb3lite_irq_gen.sv
// AHB3-lite software interrupt generator: per-IRQ level bits plus retriggerable
// fixed-length pulses, merged into registered IRQ lines.
module ahb3lite_irq_gen #(
    parameter int IRQ_CNT = 240,
    parameter int PW      = 8
) (
    input  logic               CLK,
    input  logic               RESETn,
    ahb3lite_irq_gen_if.slave  ahb,
    output logic [IRQ_CNT-1:0] IRQ
);
    localparam int              NB         = (IRQ_CNT + 31) / 32;
    localparam int              W          = NB * 32;
    localparam logic [6:0]      NB_W       = 7'(NB);
    localparam logic [W-1:0]    VALID_MASK = {W{1'b1}} >> (W - IRQ_CNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [11:0]   addr_r;
    logic          write_r;
    logic          hreadyout_r;
    logic          hresp_r;
    logic          hready_nxt_s;
    logic          hresp_nxt_s;
    logic          accept_s;
    logic          legal_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [5:0]    bank_s;
    logic [31:0]   rdata_s;

    logic [W-1:0]  level_r;
    logic [W-1:0]  level_nxt_s;
    logic [W-1:0]  pulse_trig_s;
    logic [W-1:0]  active_s;
    logic [W-1:0]  active_nxt_s;
    logic [W-1:0]  irq_nxt_s;
    logic [PW-1:0] pulse_len_r;
    logic [PW-1:0] pulse_len_nxt_s;
    logic [PW-1:0] load_val_s;
    logic [PW-1:0] cnt_r     [W];
    logic [PW-1:0] cnt_nxt_s [W];
    logic [IRQ_CNT-1:0] irq_r;
    logic          unused_s;

    // Legality of an address phase; anything not accepted here gets the two-cycle ERROR.
    function automatic logic addr_legal(input logic [11:0] addr, input logic wr, input logic [2:0] size);
        logic ok;
        logic in_bank;
        in_bank = ({1'b0, addr[7:2]} < NB_W);
        ok      = 1'b0;
        if ((size == 3'd2) && (addr[1:0] == 2'b00)) begin
            case (addr[11:8])
                4'h0, 4'h3: ok = in_bank;
                4'h1, 4'h2: ok = in_bank & wr;
                4'h4: begin
                    case (addr[7:2])
                        6'd0:    ok = 1'b1;
                        6'd1:    ok = ~wr;
                        default: ok = 1'b0;
                    endcase
                end
                default: ok = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign accept_s = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign legal_s  = addr_legal(ahb.HADDR[11:0], ahb.HWRITE, ahb.HSIZE);
    assign wr_en_s  = (state_r == ST_DATA) & write_r;
    assign rd_en_s  = (state_r == ST_DATA) & ~write_r;
    assign bank_s   = addr_r[7:2];

    assign ahb.HRDATA    = rdata_s;
    assign ahb.HREADYOUT = hreadyout_r;
    assign ahb.HRESP     = hresp_r;
    assign IRQ           = irq_r;
    assign unused_s      = ^{ahb.HBURST, ahb.HPROT, ahb.HADDR[31:12], irq_nxt_s};

    // Transfer FSM next state and the response values it will present.
    always_comb begin
        state_nxt_s  = ST_IDLE;
        hready_nxt_s = 1'b1;
        hresp_nxt_s  = 1'b0;
        case (state_r)
            ST_ERR1: state_nxt_s = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    state_nxt_s = legal_s ? ST_DATA : ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        case (state_nxt_s)
            ST_ERR1: begin
                hready_nxt_s = 1'b0;
                hresp_nxt_s  = 1'b1;
            end
            ST_ERR2: begin
                hready_nxt_s = 1'b1;
                hresp_nxt_s  = 1'b1;
            end
            default: begin
                hready_nxt_s = 1'b1;
                hresp_nxt_s  = 1'b0;
            end
        endcase
    end

    // Bus state register and address-phase capture.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r     <= ST_IDLE;
            addr_r      <= 12'd0;
            write_r     <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= hready_nxt_s;
            hresp_r     <= hresp_nxt_s;
            if (accept_s) begin
                addr_r  <= ahb.HADDR[11:0];
                write_r <= ahb.HWRITE;
            end
        end
    end

    // Data-phase write decode into level, pulse triggers and pulse length.
    always_comb begin
        level_nxt_s     = level_r;
        pulse_trig_s    = {W{1'b0}};
        pulse_len_nxt_s = pulse_len_r;
        for (int b = 0; b < NB; b++) begin
            case ({wr_en_s && (bank_s == b[5:0]), addr_r[11:8]})
                {1'b1, 4'h0}: level_nxt_s[b*32 +: 32]  = ahb.HWDATA;
                {1'b1, 4'h1}: level_nxt_s[b*32 +: 32]  = level_r[b*32 +: 32] | ahb.HWDATA;
                {1'b1, 4'h2}: level_nxt_s[b*32 +: 32]  = level_r[b*32 +: 32] & ~ahb.HWDATA;
                {1'b1, 4'h3}: pulse_trig_s[b*32 +: 32] = ahb.HWDATA;
                default: ;
            endcase
        end
        case ({wr_en_s, addr_r[11:2]})
            {1'b1, 10'h100}: pulse_len_nxt_s = ahb.HWDATA[PW-1:0];
            default: ;
        endcase
        // Bits above IRQ_CNT in the top bank never hold state.
        level_nxt_s  = level_nxt_s & VALID_MASK;
        pulse_trig_s = pulse_trig_s & VALID_MASK;
    end

    assign load_val_s = (pulse_len_r == {PW{1'b0}}) ? PW'(1) : pulse_len_r;

    // Pulse counters: a trigger reloads the full length, otherwise count down to zero.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        active_s     = {W{1'b0}};
        active_nxt_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            case ({pulse_trig_s[i], cnt_r[i] != {PW{1'b0}}})
                2'b10, 2'b11: cnt_nxt_s[i] = load_val_s;
                2'b01:        cnt_nxt_s[i] = cnt_r[i] - PW'(1);
                default:      cnt_nxt_s[i] = {PW{1'b0}};
            endcase
            active_s[i]     = (cnt_r[i] != {PW{1'b0}});
            active_nxt_s[i] = (cnt_nxt_s[i] != {PW{1'b0}});
        end
        irq_nxt_s = level_nxt_s | active_nxt_s;
    end

    // Read mux; driven straight from register state during a read data phase.
    always_comb begin
        rdata_s = 32'd0;
        for (int b = 0; b < NB; b++) begin
            case ({rd_en_s && (bank_s == b[5:0]), addr_r[11:8]})
                {1'b1, 4'h0}: rdata_s = level_r[b*32 +: 32];
                {1'b1, 4'h3}: rdata_s = active_s[b*32 +: 32];
                default: ;
            endcase
        end
        case ({rd_en_s, addr_r[11:2]})
            {1'b1, 10'h100}: rdata_s = 32'(pulse_len_r);
            {1'b1, 10'h101}: rdata_s = 32'(IRQ_CNT);
            default: ;
        endcase
    end

    // Interrupt state registers; IRQ is built from next-state so it follows a write by one cycle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            level_r     <= {W{1'b0}};
            pulse_len_r <= PW'(1);
            irq_r       <= {IRQ_CNT{1'b0}};
            for (int i = 0; i < W; i++) begin
                cnt_r[i] <= {PW{1'b0}};
            end
        end else begin
            level_r     <= level_nxt_s;
            pulse_len_r <= pulse_len_nxt_s;
            irq_r       <= irq_nxt_s[IRQ_CNT-1:0];
            cnt_r       <= cnt_nxt_s;
        end
    end
endmodule

// File: tb/tb_ahb3lite_irq_gen.sv
// Directed bench for ahb3lite_irq_gen with IRQ_CNT=40 (two banks, partial top bank).
module tb_ahb3lite_irq_gen;
    localparam int IRQ_CNT = 40;

    logic               clk;
    logic               rst_n;
    logic [IRQ_CNT-1:0] irq;
    int                 n_cmp;
    int                 n_err;
    int                 n_hi;

    ahb3lite_irq_gen_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb3lite_irq_gen #(.IRQ_CNT(IRQ_CNT), .PW(8)) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .ahb    (bus),
        .IRQ    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer; rsp = {ready1, resp1, ready2, resp2}.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic [3:0] rsp);
        @(negedge clk);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        @(negedge clk);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        rdata  = bus.HRDATA;
        rsp[3] = bus.HREADYOUT;
        rsp[2] = bus.HRESP;
        if (!bus.HREADYOUT) @(negedge clk);
        rsp[1] = bus.HREADYOUT;
        rsp[0] = bus.HRESP;
    endtask

    task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic [3:0]  rsp;
        xfer(1'b1, addr, 3'd2, data, rd, rsp);
        check_eq({tag, "_rsp"}, 64'(rsp), 64'h0A);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [3:0]  rsp;
        xfer(1'b0, addr, 3'd2, 32'd0, rd, rsp);
        check_eq(tag, 64'(rd), 64'(exp));
        check_eq({tag, "_rsp"}, 64'(rsp), 64'h0A);
    endtask

    task automatic bus_err(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] data);
        logic [31:0] rd;
        logic [3:0]  rsp;
        xfer(wr, addr, size, data, rd, rsp);
        check_eq(tag, 64'(rsp), 64'h07);
    endtask

    task automatic count_high(input int bit_idx, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (irq[bit_idx]) n++;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'd0;
        bus.HTRANS = 2'b00;
        bus.HSIZE  = 3'd2;
        bus.HBURST = 3'd0;
        bus.HPROT  = 4'd0;
        bus.HWDATA = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_irq", 64'(irq), 64'h0);
        check_eq("rst_hreadyout", 64'(bus.HREADYOUT), 64'h1);
        check_eq("rst_hresp", 64'(bus.HRESP), 64'h0);
        rst_n = 1'b1;

        bus_read("plen_rst", 32'h400, 32'd1);
        bus_read("info", 32'h404, 32'd40);

        // Level write, visible on IRQ one cycle after its data phase.
        bus_write("lvl0_w", 32'h000, 32'h0000_00A5);
        check_eq("irq_lvl0_in_dphase", 64'(irq[7:0]), 64'h00);
        @(negedge clk);
        check_eq("irq_lvl0", 64'(irq[7:0]), 64'hA5);
        bus_read("lvl0_r", 32'h000, 32'h0000_00A5);

        bus_write("lvlset1", 32'h104, 32'h3);
        @(negedge clk);
        check_eq("irq_set1", 64'(irq[33:32]), 64'h3);
        bus_write("lvlclr1", 32'h204, 32'h1);
        @(negedge clk);
        check_eq("irq_clr1", 64'(irq[33:32]), 64'h2);

        // Partial top bank keeps only bits 39:32.
        bus_write("lvl1_all", 32'h004, 32'hFFFF_FFFF);
        bus_read("lvl1_r", 32'h004, 32'h0000_00FF);
        check_eq("irq_all", 64'(irq), 64'hFF_0000_00A5);

        bus_err("err_bank2_rd", 1'b0, 32'h008, 3'd2, 32'd0);
        bus_err("err_bank2_wr", 1'b1, 32'h008, 3'd2, 32'hFFFF_FFFF);
        bus_err("err_hsize0", 1'b1, 32'h000, 3'd0, 32'd0);
        bus_err("err_info_wr", 1'b1, 32'h404, 3'd2, 32'd7);
        bus_err("err_lvlset_rd", 1'b0, 32'h100, 3'd2, 32'd0);
        bus_read("lvl0_after_err", 32'h000, 32'h0000_00A5);
        bus_read("info_after_err", 32'h404, 32'd40);
        bus_read("plen_after_err", 32'h400, 32'd1);
        check_eq("irq_after_err", 64'(irq), 64'hFF_0000_00A5);

        // Pulses.
        bus_write("lvl0_clr", 32'h000, 32'd0);
        bus_write("lvl1_clr", 32'h004, 32'd0);
        bus_write("plen4", 32'h400, 32'd4);
        bus_write("pulse_a", 32'h300, 32'h1);
        count_high(0, 16, n_hi);
        check_eq("pulse_len4", 64'(n_hi), 64'd4);

        bus_write("pulse_b", 32'h300, 32'h1);
        fork
            count_high(0, 16, n_hi);
            bus_write("pulse_retrig", 32'h300, 32'h1);
        join
        check_eq("pulse_retrig_len", 64'(n_hi), 64'd6);

        bus_write("pulse_c", 32'h300, 32'h1);
        fork
            count_high(0, 16, n_hi);
            bus_write("plen1_mid", 32'h400, 32'd1);
        join
        check_eq("pulse_len_change", 64'(n_hi), 64'd4);
        bus_read("plen1_r", 32'h400, 32'd1);

        bus_write("plen8", 32'h400, 32'd8);
        bus_write("pulse_d", 32'h300, 32'h2);
        bus_read("pulse_status_act", 32'h300, 32'h2);
        repeat (10) @(negedge clk);
        bus_read("pulse_status_idle", 32'h300, 32'h0);

        bus_write("plen0", 32'h400, 32'd0);
        bus_read("plen0_r", 32'h400, 32'd0);
        bus_write("pulse_e", 32'h300, 32'h1);
        count_high(0, 8, n_hi);
        check_eq("pulse_len0", 64'(n_hi), 64'd1);

        // Reset in the middle of a pulse.
        bus_write("plen8b", 32'h400, 32'd8);
        bus_write("lvl0_f", 32'h000, 32'h0000_000F);
        bus_write("pulse_f", 32'h300, 32'h10);
        @(negedge clk);
        check_eq("irq_pre_rst", 64'(irq[4:0]), 64'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("irq_async_rst", 64'(irq), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read("plen_post_rst", 32'h400, 32'd1);
        bus_read("lvl0_post_rst", 32'h000, 32'd0);
        bus_read("pulse_post_rst", 32'h300, 32'd0);
        check_eq("irq_post_rst", 64'(irq), 64'h0);

        // Reset in the middle of an error response.
        @(negedge clk);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h008;
        bus.HSIZE  = 3'd2;
        @(negedge clk);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        check_eq("err1_ready", 64'(bus.HREADYOUT), 64'h0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_err_ready", 64'(bus.HREADYOUT), 64'h1);
        check_eq("rst_err_resp", 64'(bus.HRESP), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_err_rst_resp", 64'({bus.HREADYOUT, bus.HRESP}), 64'h2);
        bus_read("info_final", 32'h404, 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
